rf_write_arbiter: RTL and testbench

Shares the single register-file write port between the in-order writeback stage and the long-latency multiply/divide unit (MDU). It holds one MDU result in an internal buffer and grants the port to either the writeback stage or the buffer each cycle. It asserts a stall toward the pipeline controller when the buffer takes the port from a pending writeback. It sits between the writeback stage outputs and the integer register file, and exports the buffered destination register for hazard detection.

---
 rtl/rf_write_arbiter.sv | 110 +++++++++++
 tb/tb_rf_write_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback stage vs. a one-entry MDU result buffer,
// with a bounded starvation counter that forces the buffer through under contention.
`ifndef XLEN
`define XLEN 32
`endif

module rf_write_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        wb_rd_addr_i,
  input  logic [`XLEN-1:0]  wb_rd_data_i,
  input  logic              wb_rd_we_i,
  input  logic              mdu_valid_i,
  input  logic [4:0]        mdu_rd_addr_i,
  input  logic [`XLEN-1:0]  mdu_rd_data_i,
  output logic              mdu_ready_o,
  output logic [4:0]        rf_addr_o,
  output logic [`XLEN-1:0]  rf_data_o,
  output logic              rf_we_o,
  output logic              stall_o,
  output logic [4:0]        pend_addr_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // MDU handshake: valid/ready, transfer when both high on a rising edge;
  // a transfer to x0 completes but is dropped.
  logic              buf_valid_q, buf_valid_d;
  logic [4:0]        buf_addr_q, buf_addr_d;
  logic [`XLEN-1:0]  buf_data_q, buf_data_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic [`XLEN-1:0]  rf_data_q, rf_data_d;
  logic              rf_we_q, rf_we_d;

  logic wb_req, buf_req, conflict, buf_grant, wb_grant, mdu_accept;

  always_comb begin
    wb_req     = wb_rd_we_i && (wb_rd_addr_i != 5'd0);
    buf_req    = buf_valid_q;
    conflict   = wb_req && buf_req;
    buf_grant  = buf_req && (!wb_req || (starve_cnt_q == STARVE_LIM));
    wb_grant   = wb_req && !buf_grant;
    mdu_accept = mdu_valid_i && !buf_valid_q && (mdu_rd_addr_i != 5'd0);
  end

  always_comb begin
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    rf_we_d      = 1'b0;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    starve_cnt_d = starve_cnt_q;

    if (buf_grant) begin
      rf_addr_d   = buf_addr_q;
      rf_data_d   = buf_data_q;
      rf_we_d     = 1'b1;
      buf_valid_d = 1'b0;
    end else if (wb_grant) begin
      rf_addr_d = wb_rd_addr_i;
      rf_data_d = wb_rd_data_i;
      rf_we_d   = 1'b1;
    end

    // Accept only happens with the buffer empty, so it never overlaps a drain.
    if (mdu_accept) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = mdu_rd_addr_i;
      buf_data_d  = mdu_rd_data_i;
    end

    if (buf_grant || !buf_valid_q) begin
      starve_cnt_d = 4'd0;
    end else if (conflict && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_addr_q    <= 5'd0;
      rf_data_q    <= '0;
      rf_we_q      <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= 5'd0;
      buf_data_q   <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      rf_we_q      <= rf_we_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign rf_addr_o   = rf_addr_q;
  assign rf_data_o   = rf_data_q;
  assign rf_we_o     = rf_we_q;
  assign mdu_ready_o = !buf_valid_q;
  assign stall_o     = conflict && buf_grant;
  assign pend_addr_o = buf_valid_q ? buf_addr_q : 5'd0;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: reset, single-source writes, x0 drops,
// starvation limit with forced buffer drain, and reset with a full buffer.
`ifndef XLEN
`define XLEN 32
`endif

module tb_rf_write_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        wb_rd_addr;
  logic [`XLEN-1:0]  wb_rd_data;
  logic              wb_rd_we;
  logic              mdu_valid;
  logic [4:0]        mdu_rd_addr;
  logic [`XLEN-1:0]  mdu_rd_data;
  logic              mdu_ready;
  logic [4:0]        rf_addr;
  logic [`XLEN-1:0]  rf_data;
  logic              rf_we;
  logic              stall;
  logic [4:0]        pend_addr;

  int n_assert = 0;
  int n_fail   = 0;

  rf_write_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wb_rd_addr_i  (wb_rd_addr),
    .wb_rd_data_i  (wb_rd_data),
    .wb_rd_we_i    (wb_rd_we),
    .mdu_valid_i   (mdu_valid),
    .mdu_rd_addr_i (mdu_rd_addr),
    .mdu_rd_data_i (mdu_rd_data),
    .mdu_ready_o   (mdu_ready),
    .rf_addr_o     (rf_addr),
    .rf_data_o     (rf_data),
    .rf_we_o       (rf_we),
    .stall_o       (stall),
    .pend_addr_o   (pend_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [`XLEN-1:0] obs, input logic [`XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_rd_we = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 'h55;
    mdu_valid = 1'b1; mdu_rd_addr = 5'd7; mdu_rd_data = 'h77;

    // Reset held two cycles with all inputs active
    step();
    step();
    chk("rst_we", rf_we, 0);
    chk("rst_addr", rf_addr, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_pend", pend_addr, 0);
    rst = 1'b0;
    wb_rd_we = 1'b0; mdu_valid = 1'b0;

    // Writeback only
    step();
    wb_rd_we = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 'h1234;
    settle();
    chk("wb_stall", stall, 0);
    step();
    wb_rd_we = 1'b0;
    chk("wb_we", rf_we, 1);
    chk("wb_addr", rf_addr, 5);
    chk("wb_data", rf_data, 'h1234);
    step();
    chk("idle_we", rf_we, 0);
    chk("idle_addr_hold", rf_addr, 5);
    chk("idle_data_hold", rf_data, 'h1234);

    // MDU only
    mdu_valid = 1'b1; mdu_rd_addr = 5'd7; mdu_rd_data = 'hABCD;
    settle();
    chk("mdu_ready_pre", mdu_ready, 1);
    step();
    mdu_valid = 1'b0;
    chk("mdu_ready_n1", mdu_ready, 0);
    chk("mdu_pend_n1", pend_addr, 7);
    chk("mdu_we_n1", rf_we, 0);
    step();
    chk("mdu_we_n2", rf_we, 1);
    chk("mdu_addr_n2", rf_addr, 7);
    chk("mdu_data_n2", rf_data, 'hABCD);
    chk("mdu_ready_n2", mdu_ready, 1);
    chk("mdu_pend_n2", pend_addr, 0);

    // Writeback to x0 is dropped
    wb_rd_we = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 'hFF;
    step();
    wb_rd_we = 1'b0;
    chk("wb_x0_we", rf_we, 0);

    // MDU result to x0 completes the handshake and is dropped
    mdu_valid = 1'b1; mdu_rd_addr = 5'd0; mdu_rd_data = 'hEE;
    step();
    mdu_valid = 1'b0;
    chk("mdu_x0_ready", mdu_ready, 1);
    chk("mdu_x0_pend", pend_addr, 0);
    step();
    chk("mdu_x0_we", rf_we, 0);

    // Starvation: buffer holds reg 9 under continuous writeback traffic
    mdu_valid = 1'b1; mdu_rd_addr = 5'd9; mdu_rd_data = 'h9999;
    step();
    mdu_valid = 1'b0;
    chk("starve_pend", pend_addr, 9);
    for (int i = 0; i < 4; i++) begin
      wb_rd_we = 1'b1; wb_rd_addr = 5'(10 + i); wb_rd_data = `XLEN'('h100 + i);
      settle();
      chk($sformatf("starve_stall_%0d", i), stall, 0);
      step();
      chk($sformatf("starve_wb_addr_%0d", i), rf_addr, 10 + i);
      chk($sformatf("starve_wb_data_%0d", i), rf_data, 'h100 + i);
      chk($sformatf("starve_pend_%0d", i), pend_addr, 9);
    end
    wb_rd_we = 1'b1; wb_rd_addr = 5'd20; wb_rd_data = 'h200;
    settle();
    chk("starve_stall_5th", stall, 1);
    step();
    chk("starve_buf_we", rf_we, 1);
    chk("starve_buf_addr", rf_addr, 9);
    chk("starve_buf_data", rf_data, 'h9999);
    chk("starve_after_stall", stall, 0);
    chk("starve_after_pend", pend_addr, 0);
    step();
    wb_rd_we = 1'b0;
    chk("held_wb_we", rf_we, 1);
    chk("held_wb_addr", rf_addr, 20);
    chk("held_wb_data", rf_data, 'h200);

    // Reset with a full buffer discards the result
    mdu_valid = 1'b1; mdu_rd_addr = 5'd3; mdu_rd_data = 'h3333;
    step();
    mdu_valid = 1'b0;
    chk("midrst_pend_pre", pend_addr, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ready", mdu_ready, 1);
    chk("midrst_pend", pend_addr, 0);
    chk("midrst_we", rf_we, 0);
    chk("midrst_addr", rf_addr, 0);
    step();
    chk("midrst_no_write", rf_we, 0);
    step();
    chk("midrst_no_write2", rf_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
